// File: rtl/ctrl_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// Definitions
//   Shared types for the 9-bit accumulator core control path.
//   - opcode_t : the 16 instruction opcodes (top OPC_W bits of an instruction)
//   - aluop_t  : operations understood by the ALU
//   - state_t  : control sequencer FSM states
// -----------------------------------------------------------------------------
package Definitions;

   typedef enum logic [3:0] {
      OP_LW   = 4'h0,
      OP_INC  = 4'h1,
      OP_LUV  = 4'h2,
      OP_AND  = 4'h3,
      OP_CPY  = 4'h4,
      OP_SB   = 4'h5,
      OP_GB   = 4'h6,
      OP_FLIP = 4'h7,
      OP_XOR  = 4'h8,
      OP_LOOP = 4'h9,
      OP_SHR  = 4'hA,
      OP_GOTO = 4'hB,
      OP_BEQ  = 4'hC,
      OP_RB   = 4'hD,
      OP_SW   = 4'hE,
      OP_HALT = 4'hF
   } opcode_t;

   typedef enum logic [3:0] {
      ALU_NOP  = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_CPY  = 4'd3,
      ALU_SETB = 4'd4,
      ALU_GETB = 4'd5,
      ALU_FLIP = 4'd6,
      ALU_XOR  = 4'd7,
      ALU_BXOR = 4'd8,
      ALU_SHR  = 4'd9
   } aluop_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_EXEC     = 3'd1,
      ST_MEM_WAIT = 3'd2,
      ST_FLUSH    = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

endpackage

// File: rtl/ctrl_sequencer_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
//   Purely combinational opcode decoder. Produces the raw strobes and ALU
//   operation for one instruction; the sequencer decides when they are
//   allowed to reach the datapath.
// Ports:
//   opcode       in   instruction opcode
//   zero         in   ALU zero flag, qualifies LOOP/BEQ
//   reg_wr       out  register file write
//   bit_wr       out  bit-register write
//   ctr_wr       out  counter-unit write
//   mem_wr       out  data memory write
//   goto_en      out  unconditional redirect
//   branch_taken out  conditional redirect taken
//   alu_op       out  ALU operation
//   is_load      out  opcode is LW (needs sequencing)
//   is_halt      out  opcode is HALT
// -----------------------------------------------------------------------------
module ctrl_decode
   import Definitions::*;
(
   input  opcode_t opcode,
   input  logic    zero,
   output logic    reg_wr,
   output logic    bit_wr,
   output logic    ctr_wr,
   output logic    mem_wr,
   output logic    goto_en,
   output logic    branch_taken,
   output aluop_t  alu_op,
   output logic    is_load,
   output logic    is_halt
);

   // Opcode to strobe / ALU operation table.
   always_comb begin
      reg_wr       = 1'b0;
      bit_wr       = 1'b0;
      ctr_wr       = 1'b0;
      mem_wr       = 1'b0;
      goto_en      = 1'b0;
      branch_taken = 1'b0;
      alu_op       = ALU_NOP;
      is_load      = 1'b0;
      is_halt      = 1'b0;
      case (opcode)
         OP_LW:   is_load = 1'b1;
         OP_INC:  begin ctr_wr = 1'b1; alu_op = ALU_ADD;  end
         OP_LUV:  begin reg_wr = 1'b1; alu_op = ALU_CPY;  end
         OP_AND:  begin reg_wr = 1'b1; alu_op = ALU_AND;  end
         OP_CPY:  begin reg_wr = 1'b1; alu_op = ALU_CPY;  end
         OP_SB:   begin reg_wr = 1'b1; alu_op = ALU_SETB; end
         OP_GB:   begin bit_wr = 1'b1; alu_op = ALU_GETB; end
         OP_FLIP: begin reg_wr = 1'b1; alu_op = ALU_FLIP; end
         OP_XOR:  begin bit_wr = 1'b1; alu_op = ALU_XOR;  end
         OP_LOOP: begin branch_taken = zero; alu_op = ALU_BXOR; end
         OP_SHR:  begin reg_wr = 1'b1; alu_op = ALU_SHR;  end
         OP_GOTO: goto_en = 1'b1;
         OP_BEQ:  begin branch_taken = zero; alu_op = ALU_BXOR; end
         OP_RB:   bit_wr = 1'b1;
         OP_SW:   mem_wr = 1'b1;
         OP_HALT: is_halt = 1'b1;
         default: alu_op = ALU_NOP;
      endcase
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// ctrl_sequencer
//   Multi-cycle control sequencer for the 9-bit accumulator core. Decodes the
//   registered ROM instruction, stretches loads over MEM_LAT wait cycles,
//   inserts FLUSH_CYCLES bubbles after redirects and signals completion.
//   Strobes are combinational from (state, Instruction) so they line up with
//   the datapath cycle in which the instruction is presented.
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   Start                   begin program (honoured in IDLE and DONE only)
//   Instruction, Zero       current instruction and ALU zero flag
//   PcAdvance               PC increments or redirects this cycle
//   BranchTaken, GotoEn     conditional / unconditional redirect
//   RegWrEn, MemWrEn        register file / data memory write
//   BitWriteEn              bit-register write
//   CtrUnitWriteEn          counter-unit write
//   ALUOp, CtrOffset        ALU operation, counter offset for LW/SW
//   Busy, Ack               executing / program done
//   InstrCount              saturating retired-instruction count
// -----------------------------------------------------------------------------
module ctrl_sequencer
   import Definitions::*;
#(
   parameter int INSTR_W      = 9,
   parameter int OPC_W        = 4,
   parameter int MEM_LAT      = 2,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
)(
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [INSTR_W-1:0] Instruction,
   input  logic               Zero,
   output logic               PcAdvance,
   output logic               BranchTaken,
   output logic               GotoEn,
   output logic               RegWrEn,
   output logic               MemWrEn,
   output logic               BitWriteEn,
   output logic               CtrUnitWriteEn,
   output aluop_t             ALUOp,
   output logic [1:0]         CtrOffset,
   output logic               Busy,
   output logic               Ack,
   output logic [CNT_W-1:0]   InstrCount
);

   localparam bit LOAD_WAITS = (MEM_LAT > 0);
   localparam bit HAS_FLUSH  = (FLUSH_CYCLES > 0);
   localparam int WAIT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
   localparam int FLUSH_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

   state_t              state_r;
   logic [WAIT_W-1:0]   wait_r;
   logic [FLUSH_W-1:0]  flush_r;
   logic [1:0]          lw_offset_r;
   aluop_t              lw_alu_r;
   logic [CNT_W-1:0]    count_r;

   opcode_t opcode_s;
   logic    dec_reg_wr_s, dec_bit_wr_s, dec_ctr_wr_s, dec_mem_wr_s;
   logic    dec_goto_s, dec_taken_s, dec_load_s, dec_halt_s;
   aluop_t  dec_alu_s;
   logic    unused_bits_s;

   assign opcode_s      = opcode_t'(Instruction[INSTR_W-1 -: OPC_W]);
   assign unused_bits_s = ^{Instruction[INSTR_W-OPC_W-1:3], Instruction[0]};

   ctrl_decode u_decode (
      .opcode       (opcode_s),
      .zero         (Zero),
      .reg_wr       (dec_reg_wr_s),
      .bit_wr       (dec_bit_wr_s),
      .ctr_wr       (dec_ctr_wr_s),
      .mem_wr       (dec_mem_wr_s),
      .goto_en      (dec_goto_s),
      .branch_taken (dec_taken_s),
      .alu_op       (dec_alu_s),
      .is_load      (dec_load_s),
      .is_halt      (dec_halt_s)
   );

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   // Output decode: gate the raw strobes by state; Reset blanks everything.
   always_comb begin
      PcAdvance      = 1'b0;
      BranchTaken    = 1'b0;
      GotoEn         = 1'b0;
      RegWrEn        = 1'b0;
      MemWrEn        = 1'b0;
      BitWriteEn     = 1'b0;
      CtrUnitWriteEn = 1'b0;
      ALUOp          = ALU_NOP;
      CtrOffset      = 2'b00;
      Busy           = 1'b0;
      Ack            = 1'b0;
      InstrCount     = {CNT_W{1'b0}};
      if (Reset) begin
         Busy = 1'b0;
      end else begin
         InstrCount = count_r;
         case (state_r)
            ST_EXEC: begin
               Busy           = 1'b1;
               ALUOp          = dec_alu_s;
               BranchTaken    = dec_taken_s;
               GotoEn         = dec_goto_s;
               MemWrEn        = dec_mem_wr_s;
               BitWriteEn     = dec_bit_wr_s;
               CtrUnitWriteEn = dec_ctr_wr_s;
               // A zero-latency load completes in its decode cycle.
               RegWrEn        = dec_reg_wr_s | (dec_load_s & ~LOAD_WAITS);
               PcAdvance      = ~dec_halt_s & ~(dec_load_s & LOAD_WAITS);
               if (dec_load_s || dec_mem_wr_s) begin
                  CtrOffset = Instruction[2:1];
               end else begin
                  CtrOffset = 2'b00;
               end
            end
            ST_MEM_WAIT: begin
               Busy      = 1'b1;
               ALUOp     = lw_alu_r;
               CtrOffset = lw_offset_r;
               RegWrEn   = (wait_r == {{(WAIT_W-1){1'b0}}, 1'b1});
               PcAdvance = (wait_r == {{(WAIT_W-1){1'b0}}, 1'b1});
            end
            ST_FLUSH: Busy = 1'b1;
            ST_DONE:  Ack  = 1'b1;
            ST_IDLE:  Busy = 1'b0;
            default:  Busy = 1'b0;
         endcase
      end
   end

   // Sequencer FSM with wait/flush counters, load latch and retire counter.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r     <= ST_IDLE;
         wait_r      <= {WAIT_W{1'b0}};
         flush_r     <= {FLUSH_W{1'b0}};
         lw_offset_r <= 2'b00;
         lw_alu_r    <= ALU_NOP;
         count_r     <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (Start) begin
                  state_r <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (dec_halt_s) begin
                  state_r <= ST_DONE;
               end else if (dec_load_s && LOAD_WAITS) begin
                  state_r     <= ST_MEM_WAIT;
                  wait_r      <= WAIT_W'(MEM_LAT);
                  lw_offset_r <= Instruction[2:1];
                  lw_alu_r    <= dec_alu_s;
               end else begin
                  count_r <= sat_inc(count_r);
                  if ((dec_goto_s || dec_taken_s) && HAS_FLUSH) begin
                     state_r <= ST_FLUSH;
                     flush_r <= FLUSH_W'(FLUSH_CYCLES);
                  end
               end
            end
            ST_MEM_WAIT: begin
               if (wait_r == {{(WAIT_W-1){1'b0}}, 1'b1}) begin
                  state_r <= ST_EXEC;
                  count_r <= sat_inc(count_r);
               end
               wait_r <= wait_r - {{(WAIT_W-1){1'b0}}, 1'b1};
            end
            ST_FLUSH: begin
               if (flush_r == {{(FLUSH_W-1){1'b0}}, 1'b1}) begin
                  state_r <= ST_EXEC;
               end
               flush_r <= flush_r - {{(FLUSH_W-1){1'b0}}, 1'b1};
            end
            ST_DONE: begin
               // Restart clears the count for the new run.
               if (Start) begin
                  state_r <= ST_EXEC;
                  count_r <= {CNT_W{1'b0}};
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_sequencer.sv
module tb_ctrl_sequencer;
   import Definitions::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a, reset_b, start, zero;
   logic [8:0] instr;

   logic pc_a, bt_a, go_a, rw_a, mw_a, bw_a, cw_a, busy_a, ack_a;
   logic pc_b, bt_b, go_b, rw_b, mw_b, bw_b, cw_b, busy_b, ack_b;
   logic [3:0]  alu_a, alu_b;
   logic [1:0]  co_a, co_b;
   logic [15:0] cnt_a;
   logic [2:0]  cnt_b;

   int checks = 0;
   int passed = 0;
   int count_m = 0;
   bit sel = 1'b0;   // 0: dut_a (MEM_LAT=2, FLUSH=1, CNT_W=16); 1: dut_b (0, 0, 3)

   ctrl_sequencer #(.INSTR_W(9), .OPC_W(4), .MEM_LAT(2), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
      .Clk(clk), .Reset(reset_a), .Start(start), .Instruction(instr), .Zero(zero),
      .PcAdvance(pc_a), .BranchTaken(bt_a), .GotoEn(go_a), .RegWrEn(rw_a), .MemWrEn(mw_a),
      .BitWriteEn(bw_a), .CtrUnitWriteEn(cw_a), .ALUOp(alu_a), .CtrOffset(co_a),
      .Busy(busy_a), .Ack(ack_a), .InstrCount(cnt_a));

   ctrl_sequencer #(.INSTR_W(9), .OPC_W(4), .MEM_LAT(0), .FLUSH_CYCLES(0), .CNT_W(3)) dut_b (
      .Clk(clk), .Reset(reset_b), .Start(start), .Instruction(instr), .Zero(zero),
      .PcAdvance(pc_b), .BranchTaken(bt_b), .GotoEn(go_b), .RegWrEn(rw_b), .MemWrEn(mw_b),
      .BitWriteEn(bw_b), .CtrUnitWriteEn(cw_b), .ALUOp(alu_b), .CtrOffset(co_b),
      .Busy(busy_b), .Ack(ack_b), .InstrCount(cnt_b));

   logic [14:0] vec_a, vec_b, obs_vec;
   logic [15:0] obs_cnt;
   assign vec_a   = {pc_a, bt_a, go_a, rw_a, mw_a, bw_a, cw_a, alu_a, co_a, busy_a, ack_a};
   assign vec_b   = {pc_b, bt_b, go_b, rw_b, mw_b, bw_b, cw_b, alu_b, co_b, busy_b, ack_b};
   assign obs_vec = sel ? vec_b : vec_a;
   assign obs_cnt = sel ? {13'd0, cnt_b} : cnt_a;

   // {pc, bt, goto, regwr, memwr, bitwr, ctrwr, alu[3:0], offset[1:0], busy, ack}
   function automatic logic [14:0] pack(input logic pc, input logic bt, input logic go,
                                        input logic rw, input logic mw, input logic bw,
                                        input logic cw, input logic [3:0] alu,
                                        input logic [1:0] co, input logic busy, input logic ack);
      return {pc, bt, go, rw, mw, bw, cw, alu, co, busy, ack};
   endfunction

   // Expected outputs for the cycle an instruction is presented in EXEC.
   function automatic logic [14:0] exec_expect(input logic [8:0] ins, input logic z, input int lat);
      logic [3:0] op;
      logic pc, bt, go, rw, mw, bw, cw;
      logic [3:0] alu;
      logic [1:0] co;
      op = ins[8:5];
      pc = 1'b1; bt = 1'b0; go = 1'b0; rw = 1'b0; mw = 1'b0; bw = 1'b0; cw = 1'b0;
      alu = ALU_NOP; co = 2'b00;
      case (op)
         4'h0: begin rw = (lat == 0); pc = (lat == 0); co = ins[2:1]; end
         4'h1: begin cw = 1'b1; alu = ALU_ADD;  end
         4'h2: begin rw = 1'b1; alu = ALU_CPY;  end
         4'h3: begin rw = 1'b1; alu = ALU_AND;  end
         4'h4: begin rw = 1'b1; alu = ALU_CPY;  end
         4'h5: begin rw = 1'b1; alu = ALU_SETB; end
         4'h6: begin bw = 1'b1; alu = ALU_GETB; end
         4'h7: begin rw = 1'b1; alu = ALU_FLIP; end
         4'h8: begin bw = 1'b1; alu = ALU_XOR;  end
         4'h9: begin bt = z;    alu = ALU_BXOR; end
         4'hA: begin rw = 1'b1; alu = ALU_SHR;  end
         4'hB: go = 1'b1;
         4'hC: begin bt = z;    alu = ALU_BXOR; end
         4'hD: bw = 1'b1;
         4'hE: begin mw = 1'b1; co = ins[2:1]; end
         default: pc = 1'b0;  // HALT
      endcase
      return pack(pc, bt, go, rw, mw, bw, cw, alu, co, 1'b1, 1'b0);
   endfunction

   // Present one instruction in EXEC and follow it through waits, bubbles or DONE.
   task automatic exec_instr(input logic [8:0] ins, input logic z);
      logic [3:0]  op;
      logic [14:0] e;
      int lat, fl, cmax;
      bit taken;
      op = ins[8:5];
      lat = sel ? 0 : 2;
      fl = sel ? 0 : 1;
      cmax = sel ? 7 : 65535;
      instr = ins; zero = z; start = 1'($urandom_range(0, 1));
      @(negedge clk);
      e = exec_expect(ins, z, lat);
      checks++;
      if (obs_vec !== e) $display("FAIL exec op%h: outputs %h, expected %h", op, obs_vec, e);
      else passed++;
      checks++;
      if (obs_cnt !== 16'(count_m)) $display("FAIL exec count op%h: got %0d, expected %0d", op, obs_cnt, count_m);
      else passed++;
      @(posedge clk); #1;
      if (op == 4'hF) begin
         for (int k = 0; k < 2; k++) begin
            start = (k == 1); instr = 9'($urandom);
            @(negedge clk);
            e = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_NOP, 2'b00, 1'b0, 1'b1);
            checks++;
            if (obs_vec !== e) $display("FAIL done: outputs %h, expected %h", obs_vec, e);
            else passed++;
            checks++;
            if (obs_cnt !== 16'(count_m)) $display("FAIL done count: got %0d, expected %0d", obs_cnt, count_m);
            else passed++;
            @(posedge clk); #1;
         end
         start = 1'b0;
         count_m = 0;
      end else if (op == 4'h0 && lat > 0) begin
         for (int k = 1; k <= lat; k++) begin
            instr = 9'($urandom); zero = 1'($urandom); start = 1'($urandom);
            @(negedge clk);
            e = pack(k == lat, 1'b0, 1'b0, k == lat, 1'b0, 1'b0, 1'b0, ALU_NOP, ins[2:1], 1'b1, 1'b0);
            checks++;
            if (obs_vec !== e) $display("FAIL load wait %0d: outputs %h, expected %h", k, obs_vec, e);
            else passed++;
            checks++;
            if (obs_cnt !== 16'(count_m)) $display("FAIL load count: got %0d, expected %0d", obs_cnt, count_m);
            else passed++;
            @(posedge clk); #1;
         end
         if (count_m < cmax) count_m++;
      end else begin
         if (count_m < cmax) count_m++;
         taken = (op == 4'hB) || ((op == 4'h9 || op == 4'hC) && z);
         if (taken) begin
            for (int j = 0; j < fl; j++) begin
               instr = 9'($urandom); zero = 1'($urandom); start = 1'($urandom);
               @(negedge clk);
               e = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_NOP, 2'b00, 1'b1, 1'b0);
               checks++;
               if (obs_vec !== e) $display("FAIL flush: outputs %h, expected %h", obs_vec, e);
               else passed++;
               checks++;
               if (obs_cnt !== 16'(count_m)) $display("FAIL flush count: got %0d, expected %0d", obs_cnt, count_m);
               else passed++;
               @(posedge clk); #1;
            end
         end
      end
   endtask

   // Reset both DUTs, release the selected one, and start it from IDLE.
   task automatic select_and_reset(input bit s);
      sel = s;
      reset_a = 1'b1; reset_b = 1'b1; start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (s) reset_b = 1'b0;
      else reset_a = 1'b0;
      count_m = 0;
      start = 1'b1;
      @(negedge clk);
      checks++;
      if (obs_vec !== 15'd0 || obs_cnt !== 16'd0)
         $display("FAIL idle: outputs %h count %0d, expected all zero", obs_vec, obs_cnt);
      else passed++;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset_a = 1'b1; reset_b = 1'b1; start = 1'b1; zero = 1'b1; instr = 9'h1A3;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         instr = 9'($urandom);
         @(negedge clk);
         checks++;
         if (vec_a !== 15'd0 || cnt_a !== 16'd0)
            $display("FAIL reset a: outputs %h count %0d, expected zero", vec_a, cnt_a);
         else passed++;
         checks++;
         if (vec_b !== 15'd0 || cnt_b !== 3'd0)
            $display("FAIL reset b: outputs %h count %0d, expected zero", vec_b, cnt_b);
         else passed++;
      end
   endtask

   task automatic test_basic_stream();
      select_and_reset(1'b0);
      exec_instr({4'h3, 5'b10110}, 1'b0);  // AND
      exec_instr({4'h4, 5'b00001}, 1'b1);  // CPY
      exec_instr({4'hE, 5'b00010}, 1'b0);  // SW offset 01
      @(negedge clk);
      checks++;
      if (obs_cnt !== 16'd3) $display("FAIL stream count: got %0d, expected 3", obs_cnt);
      else passed++;
      @(posedge clk); #1;
      count_m = 0;
      select_and_reset(1'b0);
   endtask

   task automatic test_load();
      select_and_reset(1'b0);
      exec_instr({4'h0, 5'b01100}, 1'b0);  // LW offset 10
      exec_instr({4'h0, 5'b00011}, 1'b1);  // LW offset 01
      exec_instr({4'h2, 5'b00000}, 1'b0);
   endtask

   task automatic test_branch();
      select_and_reset(1'b0);
      exec_instr({4'hC, 5'b01010}, 1'b1);  // BEQ taken -> bubble
      exec_instr({4'hC, 5'b01010}, 1'b0);  // BEQ not taken
      exec_instr({4'h9, 5'b00000}, 1'b1);  // LOOP taken
      exec_instr({4'hB, 5'b11111}, 1'b0);  // GOTO
      exec_instr({4'h6, 5'b00000}, 1'b0);
   endtask

   task automatic test_halt();
      select_and_reset(1'b0);
      for (int i = 0; i < 5; i++) exec_instr({4'($urandom_range(0, 14)), 5'($urandom)}, 1'($urandom));
      exec_instr({4'hF, 5'd0}, 1'b0);
      exec_instr({4'h1, 5'd0}, 1'b0);
   endtask

   task automatic test_reset_midload();
      select_and_reset(1'b0);
      exec_instr({4'h1, 5'd0}, 1'b0);
      exec_instr({4'h2, 5'd0}, 1'b0);
      instr = {4'h0, 5'b00110}; zero = 1'b0;
      @(negedge clk);
      checks++;
      if (rw_a !== 1'b0 || pc_a !== 1'b0 || co_a !== 2'b11)
         $display("FAIL midload exec: rw %b pc %b off %0d, expected 0 0 3", rw_a, pc_a, co_a);
      else passed++;
      @(posedge clk); #1;
      instr = 9'($urandom);
      @(posedge clk); #1;
      reset_a = 1'b1;
      @(negedge clk);
      checks++;
      if (vec_a !== 15'd0 || cnt_a !== 16'd0)
         $display("FAIL midload reset: outputs %h count %0d, expected zero", vec_a, cnt_a);
      else passed++;
      @(posedge clk); #1;
      reset_a = 1'b0; start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (vec_a !== 15'd0 || cnt_a !== 16'd0)
            $display("FAIL midload idle: outputs %h count %0d, expected zero", vec_a, cnt_a);
         else passed++;
         @(posedge clk); #1;
      end
      count_m = 0;
   endtask

   task automatic test_saturate();
      select_and_reset(1'b1);
      exec_instr({4'h0, 5'b00100}, 1'b0);  // single-cycle LW
      exec_instr({4'hB, 5'b00000}, 1'b0);  // GOTO, no bubble
      exec_instr({4'hC, 5'b00000}, 1'b1);  // BEQ taken, no bubble
      for (int i = 0; i < 9; i++) exec_instr({4'h1, 5'($urandom)}, 1'($urandom));
      @(negedge clk);
      checks++;
      if (obs_cnt !== 16'd7) $display("FAIL saturate: got %0d, expected 7", obs_cnt);
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      select_and_reset(1'b0);
      for (int i = 0; i < 200; i++) exec_instr(9'($urandom), 1'($urandom));
      select_and_reset(1'b1);
      for (int i = 0; i < 100; i++) exec_instr(9'($urandom), 1'($urandom));
   endtask

   initial begin
      test_reset();
      test_basic_stream();
      test_load();
      test_branch();
      test_halt();
      test_reset_midload();
      test_saturate();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Multi-cycle control sequencer for the 9-bit accumulator-style core. It replaces the purely combinational decoder with an FSM that decodes each instruction and handles multi-cycle loads. It also resolves branches against the ALU Zero flag, inserts flush bubbles after redirects, and reports program completion. It sits between the registered instruction ROM output and the fetch unit, register file, bit register, counter unit and data memory.

Parameters:
INSTR_W, 9, instruction width in bits
OPC_W, 4, opcode width; opcode = Instruction[INSTR_W-1 -: OPC_W]
MEM_LAT, 2, extra wait cycles for a data-memory load (0 = single-cycle load)
FLUSH_CYCLES, 1, bubble cycles after a taken branch or goto (0 = none)
CNT_W, 16, width of retired-instruction counter

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high reset
Start  in  1  begin program execution (level sampled at Clk edge)
Instruction  in  INSTR_W  registered instruction ROM output
Zero  in  1  ALU zero flag for the current cycle
PcAdvance  out  1  fetch unit increments or redirects PC this cycle
BranchTaken  out  1  conditional redirect (LOOP/BEQ with Zero=1)
GotoEn  out  1  unconditional redirect
RegWrEn  out  1  register file write
MemWrEn  out  1  data memory write
BitWriteEn  out  1  bit-register write
CtrUnitWriteEn  out  1  counter-unit write
ALUOp  out  4  ALU operation (package enum)
CtrOffset  out  2  counter offset = Instruction[2:1] for LW/SW, else 0
Busy  out  1  high in EXEC, MEM_WAIT, FLUSH
Ack  out  1  program done
InstrCount  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, EXEC, MEM_WAIT, FLUSH, DONE. Reset: state IDLE, wait/flush counters 0, InstrCount 0.
- While Reset=1, all outputs are forced to 0 in that same cycle, whatever the state.
- IDLE: all outputs 0. Start=1 -> EXEC.
- EXEC: decode Instruction combinationally; strobes are valid in the same cycle. Opcodes:
  - 0 LW, 1 INC, 2 LUV, 3 AND, 4 CPY, 5 SB, 6 GB, 7 FLIP
  - 8 XOR, 9 LOOP, A SHR, B GOTO, C BEQ, D RB, E SW, F HALT
- Strobe decode:
  - RegWrEn: LUV, AND, CPY, SB, FLIP, SHR.
  - BitWriteEn: GB, XOR, RB.
  - CtrUnitWriteEn: INC.
  - MemWrEn: SW.
  - GotoEn: GOTO.
  - BranchTaken: (LOOP or BEQ) and Zero.
- ALUOp decode: INC=ADD; LUV/CPY=CPY; AND=AND; SB=SETB; GB=GETB; FLIP=FLIP; XOR=XOR; LOOP/BEQ=BXOR; SHR=SHR; all other opcodes = NOP.
- Single-cycle ops: PcAdvance=1, retire (InstrCount+1), remain in EXEC.
- LW with MEM_LAT=0: behaves as a single-cycle op with RegWrEn=1.
- LW with MEM_LAT>0:
  - EXEC cycle: PcAdvance=0, RegWrEn=0; go to MEM_WAIT with wait counter=MEM_LAT.
  - MEM_WAIT: counter decrements each cycle. CtrOffset and ALUOp are held from the latched LW instruction, not the live Instruction input.
  - Final MEM_WAIT cycle (counter==1): RegWrEn=1, PcAdvance=1, retire, return to EXEC.
  - Total LW latency is MEM_LAT+1 cycles.
- Taken branch or GOTO: PcAdvance=1, retire.
  - FLUSH_CYCLES>0: go to FLUSH. In FLUSH all strobes and PcAdvance are 0 and Instruction is ignored; after FLUSH_CYCLES cycles return to EXEC.
  - FLUSH_CYCLES=0: stay in EXEC.
  - Untaken branch: ordinary single-cycle op, no flush.
- HALT in EXEC: no strobes, no retire, PcAdvance=0; go to DONE.
- DONE: Ack=1, Busy=0, InstrCount frozen. Start=1 -> EXEC with InstrCount cleared to 0 on that edge.
- Start is ignored outside IDLE and DONE.
- InstrCount saturates at all-ones; it never wraps.
- Reset mid-operation (MEM_WAIT, FLUSH, DONE): takes effect at the next edge. A pending load write is never issued.

Decomposition:
- Shared package `Definitions`:
  - opcode enum (16 values above);
  - ALU op enum (NOP, ADD, AND, CPY, SETB, GETB, FLIP, XOR, BXOR, SHR), 4 bits;
  - FSM state typedef.
- One sub-module `ctrl_decode`: purely combinational opcode -> strobe/ALUOp mapping. The FSM in `ctrl_sequencer` gates and sequences its outputs.

Test Plan:
- Reset 2 cycles, Start=1, stream AND, CPY, SW(Instruction[2:1]=01) -> RegWrEn=1,1,0; MemWrEn=0,0,1; CtrOffset=1 on SW; PcAdvance=1 every cycle; InstrCount=3.
- MEM_LAT=2, LW with Instruction[2:1]=10 -> PcAdvance=0 for 2 cycles then 1; RegWrEn=1 only on 3rd cycle; CtrOffset=2 in all 3 cycles; InstrCount+1.
- BEQ with Zero=1, FLUSH_CYCLES=1 -> BranchTaken=1, ALUOp=BXOR for 1 cycle, then 1 cycle with all strobes and PcAdvance 0. Same instruction with Zero=0 -> no BranchTaken, no bubble.
- HALT after 5 ops -> Ack=1 next cycle, Busy=0, InstrCount=5 held. Start=1 -> EXEC, InstrCount=0.
- Reset=1 during MEM_WAIT -> all outputs 0 that cycle, IDLE next, InstrCount=0, RegWrEn never asserted for that LW.
- CNT_W=3, 9 INC ops -> CtrUnitWriteEn=1, ALUOp=ADD each cycle; InstrCount stops at 7.
